control_sequencer: RTL

- Multi-cycle hardwired control unit for the 32-bit bus datapath.
- Walks fetch and execute steps one step per clock.
- Decodes the IR opcode and drives every datapath strobe: register select, bus-out enables, register loads, ALU op, and RAM read/write.
- Sits between IR/CON_FF and the datapath. It replaces the testbench-driven control inputs.

---
 rtl/control_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: steps through fetch (T0..T2) and the
// opcode-specific execute steps (T3..T7), one step per clock, and decodes
// every datapath strobe combinationally from the current step and ir.
module control_sequencer #(
  parameter int unsigned     OPW    = 5,
  parameter logic [OPW-1:0]  ADD_OP = 5'b00011
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           stop,
  input  logic [31:0]    ir,
  input  logic           con,
  output logic           run,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           PCout,
  output logic           PCin,
  output logic           IncPC,
  output logic           IRin,
  output logic           MARin,
  output logic           MDRin,
  output logic           MDRout,
  output logic           HIin,
  output logic           HIout,
  output logic           LOin,
  output logic           LOout,
  output logic           Zin,
  output logic           Zhighout,
  output logic           Zlowout,
  output logic           Yin,
  output logic           Cout,
  output logic           InPortout,
  output logic           Out_portIn,
  output logic           CONin,
  output logic           read,
  output logic           RAMwrite,
  output logic [OPW-1:0] alu_op
);

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  localparam logic [OPW-1:0] OpLd   = OPW'(0);
  localparam logic [OPW-1:0] OpLdi  = OPW'(1);
  localparam logic [OPW-1:0] OpSt   = OPW'(2);
  localparam logic [OPW-1:0] OpAdd  = OPW'(3);
  localparam logic [OPW-1:0] OpShl  = OPW'(11);
  localparam logic [OPW-1:0] OpAddi = OPW'(12);
  localparam logic [OPW-1:0] OpOri  = OPW'(14);
  localparam logic [OPW-1:0] OpDiv  = OPW'(15);
  localparam logic [OPW-1:0] OpMul  = OPW'(16);
  localparam logic [OPW-1:0] OpNeg  = OPW'(17);
  localparam logic [OPW-1:0] OpNot  = OPW'(18);
  localparam logic [OPW-1:0] OpBr   = OPW'(19);
  localparam logic [OPW-1:0] OpJr   = OPW'(20);
  localparam logic [OPW-1:0] OpIn   = OPW'(22);
  localparam logic [OPW-1:0] OpOut  = OPW'(23);
  localparam logic [OPW-1:0] OpMflo = OPW'(24);
  localparam logic [OPW-1:0] OpMfhi = OPW'(25);
  localparam logic [OPW-1:0] OpHalt = OPW'(27);

  state_e         state_q, state_d;
  state_e         last_step;
  state_e         end_state;
  logic [OPW-1:0] opcode;
  logic           is_alu, is_imm, is_muldiv, is_neg, is_ld, is_ldi, is_st, is_br;
  logic           is_jr, is_in, is_out, is_mflo, is_mfhi, is_halt;
  logic           unused_ir;

  assign opcode    = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];

  assign is_alu    = (opcode >= OpAdd) && (opcode <= OpShl);
  assign is_imm    = (opcode >= OpAddi) && (opcode <= OpOri);
  assign is_muldiv = (opcode == OpDiv) || (opcode == OpMul);
  assign is_neg    = (opcode == OpNeg) || (opcode == OpNot);
  assign is_ld     = (opcode == OpLd);
  assign is_ldi    = (opcode == OpLdi);
  assign is_st     = (opcode == OpSt);
  assign is_br     = (opcode == OpBr);
  assign is_jr     = (opcode == OpJr);
  assign is_in     = (opcode == OpIn);
  assign is_out    = (opcode == OpOut);
  assign is_mflo   = (opcode == OpMflo);
  assign is_mfhi   = (opcode == OpMfhi);
  assign is_halt   = (opcode == OpHalt);

  // Step register; clear forces RESET at any time.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= StReset;
    else        state_q <= state_d;
  end

  // Final step of the current instruction; nop and unlisted opcodes end at T2.
  always_comb begin
    last_step = StT2;
    if (is_alu || is_imm || is_ldi)                        last_step = StT5;
    else if (is_muldiv || is_br)                           last_step = StT6;
    else if (is_neg)                                       last_step = StT4;
    else if (is_ld || is_st)                               last_step = StT7;
    else if (is_jr || is_in || is_out || is_mflo || is_mfhi) last_step = StT3;
  end

  // Next step: advance, or leave the instruction (stop only counts here).
  always_comb begin
    end_state = stop ? StHalt : StT0;
    state_d   = state_q;
    case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2: begin
        if (is_halt)                state_d = StHalt;
        else if (last_step == StT2) state_d = end_state;
        else                        state_d = StT3;
      end
      StT3:    state_d = (last_step == StT3) ? end_state : StT4;
      StT4:    state_d = (last_step == StT4) ? end_state : StT5;
      StT5:    state_d = (last_step == StT5) ? end_state : StT6;
      StT6:    state_d = (last_step == StT6) ? end_state : StT7;
      StT7:    state_d = end_state;
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  // Strobe decode from current step and opcode.
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
     HIin, HIout, LOin, LOout, Zin, Zhighout, Zlowout, Yin, Cout, InPortout, Out_portIn,
     CONin, read, RAMwrite} = '0;
    alu_op = '0;
    run    = (state_q != StReset) && (state_q != StHalt);
    case (state_q)
      StT0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      StT1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
      StT2: begin MDRout = 1'b1; IRin = 1'b1; end
      StT3: begin
        if (is_alu || is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_muldiv) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_neg) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
        else if (is_ld || is_ldi || is_st) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (is_br) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        else if (is_jr) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        else if (is_in) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_out) begin Gra = 1'b1; Rout = 1'b1; Out_portIn = 1'b1; end
        else if (is_mflo) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_mfhi) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      StT4: begin
        if (is_alu) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
        else if (is_imm) begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
        else if (is_muldiv) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
        else if (is_neg) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_ld || is_ldi || is_st) begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
        else if (is_br) begin PCout = 1'b1; Yin = 1'b1; end
      end
      StT5: begin
        if (is_alu || is_imm || is_ldi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_muldiv) begin Zlowout = 1'b1; LOin = 1'b1; end
        else if (is_ld || is_st) begin Zlowout = 1'b1; MARin = 1'b1; end
        else if (is_br) begin Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP; end
      end
      StT6: begin
        if (is_muldiv) begin Zhighout = 1'b1; HIin = 1'b1; end
        else if (is_ld) begin read = 1'b1; MDRin = 1'b1; end
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else if (is_br && con) begin Zlowout = 1'b1; PCin = 1'b1; end
      end
      StT7: begin
        if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st) RAMwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
